// File: rtl/sp_fp_divider.sv
// IEEE-754 single-precision divider: iterative restoring division, FTZ, no denormal output.
// Define SP_FP_DIV_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module sp_fp_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic        div_by_zero,
  output logic        invalid
);

  typedef enum logic [2:0] {
    IDLE, CHECK, DIVIDE, NORM, DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0] a_q, b_q;
  logic [4:0]  cnt;
  logic [24:0] rem;
  logic [25:0] q;
  logic signed [9:0] exp_q;
  logic [31:0] res_q;
  logic        dbz_q, inv_q;

  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        sgn;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        special;
  logic [31:0] spec_res;
  logic        spec_dbz, spec_inv;

  logic [24:0] dvsr;
  logic        ge;
  logic [23:0] rem_sub;

  logic [22:0] frac;
  logic signed [9:0] e_n, e_r;
  logic        rnd_up;
  logic [23:0] sum;
  logic [31:0] norm_res;
`ifdef SP_FP_DIV_ROUND_EN
  logic        guard, sticky;
`endif

  assign ea  = a_q[30:23];
  assign eb  = b_q[30:23];
  assign ma  = a_q[22:0];
  assign mb  = b_q[22:0];
  assign sgn = a_q[31] ^ b_q[31];

  assign busy = (state != IDLE);

  // Operand classification; exponent 0 means zero since denormals are flushed.
  always_comb begin
    a_nan    = (ea == 8'hFF) && (ma != 23'd0);
    b_nan    = (eb == 8'hFF) && (mb != 23'd0);
    a_inf    = (ea == 8'hFF) && (ma == 23'd0);
    b_inf    = (eb == 8'hFF) && (mb == 23'd0);
    a_zero   = (ea == 8'h00);
    b_zero   = (eb == 8'h00);
    special  = 1'b1;
    spec_dbz = 1'b0;
    spec_inv = 1'b0;
    spec_res = {sgn, 31'd0};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = 32'h7FC00000;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_res = {sgn, 8'hFF, 23'd0};
    end else if (b_zero) begin
      spec_res = {sgn, 8'hFF, 23'd0};
      spec_dbz = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_res = {sgn, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring step: subtract the divisor when it fits.
  always_comb begin
    dvsr    = {2'b01, mb};
    ge      = (rem >= dvsr);
    rem_sub = ge ? 24'(rem - dvsr) : rem[23:0];
  end

  // Normalise, optionally round, then clamp the exponent range.
  always_comb begin
    if (q[25]) begin
      frac = q[24:2];
      e_n  = exp_q;
    end else begin
      frac = q[23:1];
      e_n  = exp_q - 10'sd1;
    end
`ifdef SP_FP_DIV_ROUND_EN
    guard  = q[25] ? q[1] : q[0];
    sticky = (q[25] & q[0]) | (|rem);
    rnd_up = guard & (sticky | frac[0]);
`else
    rnd_up = 1'b0;
`endif
    sum = {1'b0, frac} + {23'd0, rnd_up};
    e_r = e_n + $signed({9'd0, sum[23]});
    if (e_r >= 10'sd255)
      norm_res = {sgn, 8'hFF, 23'd0};
    else if (e_r <= 10'sd0)
      norm_res = {sgn, 31'd0};
    else
      norm_res = {sgn, e_r[7:0], sum[22:0]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CHECK;
      CHECK:   state_nx = special ? DONE : DIVIDE;
      DIVIDE:  if (cnt == 5'd25) state_nx = NORM;
      NORM:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, division iterations, internal result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      cnt   <= 5'd0;
      rem   <= 25'd0;
      q     <= 26'd0;
      exp_q <= 10'sd0;
      res_q <= 32'd0;
      dbz_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          a_q <= op_a;
          b_q <= op_b;
        end
        CHECK: begin
          cnt   <= 5'd0;
          rem   <= {2'b01, ma};
          q     <= 26'd0;
          exp_q <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
          res_q <= spec_res;
          dbz_q <= spec_dbz;
          inv_q <= spec_inv;
        end
        DIVIDE: begin
          cnt <= cnt + 5'd1;
          q   <= {q[24:0], ge};
          rem <= {rem_sub, 1'b0};
        end
        NORM: begin
          res_q <= norm_res;
          dbz_q <= 1'b0;
          inv_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs: one-cycle done pulse, result and flags held until next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      quotient    <= 32'd0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        quotient    <= res_q;
        div_by_zero <= dbz_q;
        invalid     <= inv_q;
      end else if (state == IDLE && start) begin
        div_by_zero <= 1'b0;
        invalid     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sp_fp_divider.sv
// Scoreboard bench for sp_fp_divider: driver pushes expectations,
// monitor pops and checks result, flags and latency on each done.
module tb_sp_fp_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        busy, done, div_by_zero, invalid;
  logic [31:0] quotient;

  sp_fp_divider dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .quotient(quotient),
    .div_by_zero(div_by_zero), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic        dbz;
    logic        inv;
    int          lat;
    int          st;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

`ifdef SP_FP_DIV_ROUND_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got %h want none", quotient);
      end else begin
        e = sbq.pop_front();
        chk("quotient", quotient, e.q);
        chk("flags", {30'd0, div_by_zero, invalid}, {30'd0, e.dbz, e.inv});
        chk("latency", 32'(cyc - e.st), 32'(e.lat));
      end
    end
  end

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] qx, input logic dz,
                     input logic iv, input int lat, input int poke);
    exp_t e;
    int bc;
    bit got;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a  = 32'hDEADBEEF;
    op_b  = 32'h12345678;
    e.q = qx; e.dbz = dz; e.inv = iv; e.lat = lat; e.st = cyc;
    sbq.push_back(e);
    bc  = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (i > 0) @(negedge clk);
      start = 1'b0;
      if (i == poke) begin
        start = 1'b1;
        op_a  = 32'h3F800000;
        op_b  = 32'h3F800000;
      end
      if (done === 1'b1) got = 1'b1;
      else if (busy === 1'b1) bc++;
    end
    start = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done want done for %h/%h", a, b);
    end else begin
      chk("busy_cycles", 32'(bc), 32'(lat));
    end
    repeat (3) @(negedge clk);
    chk("held", quotient, qx);
    chk("idle_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out", {quotient}, 32'd0);
    chk("rst_flags", {29'd0, done, div_by_zero, invalid}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;

    run(32'h3F800000, 32'hBF800000, 32'hBF800000, 0, 0, 29, -1);
    run(32'h40490FDB, 32'h40000000, 32'h3FC90FDB, 0, 0, 29, -1);
    run(32'h3F800000, 32'h40400000, THIRD,        0, 0, 29, 5);
    run(32'hC0C00000, 32'h40000000, 32'hC0400000, 0, 0, 29, -1);
    run(32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0, 2, 1);
    run(32'h00000000, 32'h00000000, 32'h7FC00000, 0, 1, 2, -1);
    run(32'hFFFFFFFF, 32'h00112233, 32'h7FC00000, 0, 1, 2, -1);
    run(32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 2, -1);
    run(32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 0, 0, 29, -1);
    run(32'h80800000, 32'h7F7FFFFF, 32'h80000000, 0, 0, 29, -1);
    run(32'h00112233, 32'h3F800000, 32'h00000000, 0, 0, 2, -1);

    @(negedge clk);
    op_a  = 32'h3F800000;
    op_b  = 32'h40400000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    saw = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw}, 32'd0);

    run(32'h44556677, 32'h3F800000, 32'h44556677, 0, 0, 29, -1);

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_fp_divider.md
SP_FP_DIVIDER -- requirements
Module: sp_fp_divider

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed to IEEE-754 single precision.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op_a  input  32  dividend, captured on an accepted start.
REQ-007 op_b  input  32  divisor, captured on an accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when the quotient is valid.
REQ-010 quotient  output  32  result; held from done until the next accepted start.
REQ-011 div_by_zero  output  1  finite nonzero / zero; valid with done and held with quotient.
REQ-012 invalid  output  1  0/0, inf/inf or any NaN operand; valid with done and held with quotient.

Function
REQ-013 The FSM SHALL have states IDLE, CHECK, DIVIDE, NORM and DONE.
REQ-014 Transitions SHALL be:
- IDLE->CHECK on start at edge N, capturing operands.
- CHECK->DONE for special cases, otherwise CHECK->DIVIDE.
- DIVIDE runs 26 cycles, then ->NORM.
- NORM->DONE.
- DONE->IDLE.
REQ-015 Latency SHALL be counted from the edge that samples start:
- done is high in cycle N+29 for normal operands.
- done is high in cycle N+2 for special cases.
REQ-016 start SHALL be ignored while busy, including in the DONE cycle.
REQ-017 Denormal operands SHALL be treated as signed zero (flush-to-zero).
REQ-018 Special cases SHALL resolve as follows:
- Any NaN operand, 0/0 or inf/inf -> 0x7FC00000 with invalid=1.
- Finite nonzero / 0 -> signed inf with div_by_zero=1.
- inf/finite -> signed inf.
- 0/nonzero or finite/inf -> signed zero.
REQ-019 The result sign SHALL be sign_a XOR sign_b for all non-NaN results.
REQ-020 Exponent SHALL be computed as ea - eb + 127 in a 10-bit signed intermediate.
REQ-021 DIVIDE SHALL perform restoring division of {1,ma} by {1,mb}, one quotient bit per cycle, 26 bits, with q[25] weighted 2^0.
REQ-022 NORM SHALL normalise the quotient:
- If q[25]=0, shift the quotient left 1 and decrement the exponent.
- Use 23 fraction bits plus a guard bit.
- The sticky bit is the OR of the remaining quotient bit and (remainder != 0).
REQ-023 A post-normalise biased exponent >= 255 SHALL produce signed inf (0x7F800000 / 0xFF800000), evaluated after rounding.
REQ-024 A post-normalise biased exponent <= 0 SHALL produce signed zero; no denormals are produced.
REQ-025 flags SHALL be cleared on every accepted start.

Reset
REQ-026 While rst is high at an edge:
- The FSM goes to IDLE.
- busy, done, div_by_zero and invalid are cleared to 0.
- quotient is cleared to 0x00000000.
- Internal counter and remainder are cleared to 0.
REQ-027 rst SHALL win over start in the same cycle.
REQ-028 An operation aborted by rst SHALL never assert done.

Configuration
REQ-029 When macro SP_FP_DIV_ROUND_EN is defined, the block SHALL round to nearest-even:
- Increment if guard AND (sticky OR lsb).
- A mantissa carry-out renormalises to 1.0 and increments the exponent.
REQ-030 When SP_FP_DIV_ROUND_EN is undefined, the block SHALL truncate (guard and sticky discarded).
REQ-031 Latency SHALL be identical with and without SP_FP_DIV_ROUND_EN.

Verification
REQ-032 0x3F800000 / 0xBF800000 -> quotient 0xBF800000, flags 0, done exactly 29 cycles after start, busy high 29 cycles.
REQ-033 0x40490FDB / 0x40000000 -> 0x3FC90FDB; 0x3F800000 / 0x40400000 -> 0x3EAAAAAB with SP_FP_DIV_ROUND_EN, 0x3EAAAAAA without.
REQ-034 Special-case inputs SHALL respond with done 2 cycles after start:
- 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1.
- 0x00000000 / 0x00000000 -> 0x7FC00000, invalid=1.
- 0xFFFFFFFF / 0x00112233 -> 0x7FC00000, invalid=1.
REQ-035 Range-limit inputs SHALL respond as follows:
- 0x7F7FFFFF / 0x00800000 -> 0x7F800000.
- 0x80800000 / 0x7F7FFFFF -> 0x80000000.
- 0x00112233 / 0x3F800000 -> 0x00000000 (FTZ).
REQ-036 Handshake and reset SHALL behave as follows:
- A second start pulsed during busy is ignored and the first result is unchanged.
- rst asserted at cycle 10 of DIVIDE -> busy=0 next cycle, no done.
- The following start 0x44556677 / 0x3F800000 returns 0x44556677 after 29 cycles.
